apb_serial_master: RTL and testbench



---
 rtl/apb_serial_master_if.sv | 20 ++
 rtl/apb_serial_master.sv | 191 +++++++++++++++++++
 tb/tb_apb_serial_master.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/apb_serial_master_if.sv
// APB bus bundle between apb_serial_master (initiator) and the peripheral interconnect.
interface apb_serial_master_if;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/apb_serial_master.sv
// Byte-stream command decoder driving one APB transfer per frame and returning ack/read bytes.
// Optional ACCESS-phase timeout is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_serial_master #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd255
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  apb_serial_master_if.master        apb,
  output logic                       busy,
  output logic                       drop_err
);

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t      state, next_state;
  logic [1:0]  byte_cnt;
  logic [31:0] addr_sh;
  logic [31:0] wdata_sh;
  logic [31:0] resp_sh;
  logic [1:0]  resp_idx;
  logic [1:0]  resp_last;
  logic        timeout;
  logic        tx_done;

  assign tx_done = tx_valid && tx_ready;

`ifdef APB_MASTER_TIMEOUT_EN
  logic [15:0] acc_cnt;
  // acc_cnt counts completed ACCESS cycles; the current one makes it +1
  assign timeout = !apb.PREADY &&
                   (({1'b0, acc_cnt} + 17'd1) == {1'b0, TIMEOUT_CYCLES});
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state  = state;
    apb.PSEL    = 1'b0;
    apb.PENABLE = 1'b0;
    busy        = (state != S_IDLE);
    unique case (state)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_W || rx_data == CMD_R) next_state = S_ADDR;
          else                                      next_state = S_RESP;
        end
      end
      S_ADDR: begin
        if (rx_valid && byte_cnt == 2'd3)
          next_state = apb.PWRITE ? S_DATA : S_SETUP;
      end
      S_DATA: begin
        if (rx_valid && byte_cnt == 2'd3) next_state = S_SETUP;
      end
      S_SETUP: begin
        apb.PSEL   = 1'b1;
        next_state = S_ACCESS;
      end
      S_ACCESS: begin
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b1;
        if (apb.PREADY || timeout) next_state = S_RESP;
      end
      S_RESP: begin
        if (tx_done && resp_idx == resp_last) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      byte_cnt   <= '0;
      addr_sh    <= '0;
      wdata_sh   <= '0;
      resp_sh    <= '0;
      resp_idx   <= '0;
      resp_last  <= '0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      drop_err   <= 1'b0;
      apb.PADDR  <= '0;
      apb.PWDATA <= '0;
      apb.PWRITE <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      acc_cnt    <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (rx_valid) begin
            byte_cnt <= '0;
            if (rx_data == CMD_W || rx_data == CMD_R) begin
              apb.PWRITE <= (rx_data == CMD_W);
            end else begin
              tx_valid  <= 1'b1;
              tx_data   <= NAK;
              resp_idx  <= '0;
              resp_last <= '0;
            end
          end
        end
        S_ADDR: begin
          if (rx_valid) begin
            addr_sh  <= {addr_sh[23:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3 && !apb.PWRITE)
              apb.PADDR <= {addr_sh[23:0], rx_data};
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            wdata_sh <= {wdata_sh[23:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              apb.PADDR  <= addr_sh;
              apb.PWDATA <= {wdata_sh[23:0], rx_data};
            end
          end
        end
        S_SETUP: begin
`ifdef APB_MASTER_TIMEOUT_EN
          acc_cnt <= '0;
`endif
        end
        S_ACCESS: begin
          if (apb.PREADY) begin
            tx_valid <= 1'b1;
            resp_idx <= '0;
            if (apb.PWRITE) begin
              tx_data   <= ACK;
              resp_last <= '0;
            end else begin
              tx_data   <= apb.PRDATA[31:24];
              resp_sh   <= apb.PRDATA;
              resp_last <= 2'd3;
            end
          end else if (timeout) begin
            tx_valid  <= 1'b1;
            tx_data   <= NAK;
            resp_idx  <= '0;
            resp_last <= '0;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else begin
            acc_cnt <= acc_cnt + 16'd1;
          end
`endif
        end
        S_RESP: begin
          if (tx_done) begin
            if (resp_idx == resp_last) begin
              tx_valid <= 1'b0;
            end else begin
              resp_idx <= resp_idx + 2'd1;
              tx_data  <= resp_sh[23:16];
              resp_sh  <= {resp_sh[23:0], 8'h00};
            end
          end
        end
        default: ;
      endcase

      if (rx_valid && (state == S_SETUP || state == S_ACCESS || state == S_RESP))
        drop_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_apb_serial_master.sv
// Directed bench for apb_serial_master: table of command frames plus hand-written corner sequences.
module tb_apb_serial_master;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       drop_err;

  int checks   = 0;
  int failures = 0;
  logic exp_drop = 1'b0;

  apb_serial_master_if bus ();

  apb_serial_master #(.TIMEOUT_CYCLES(16'd4)) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .apb      (bus),
    .busy     (busy),
    .drop_err (drop_err)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] prdata;
    int          waits;
    logic        toggle;
    logic        drop;
  } vec_t;

  vec_t tbl [5];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    int nb;
    int idx;
    int guard;
    logic [7:0] eb;
    send_byte(v.wr ? 8'h57 : 8'h52);
    for (int i = 3; i >= 0; i--) send_byte(v.addr[8*i +: 8]);
    if (v.wr) for (int i = 3; i >= 0; i--) send_byte(v.data[8*i +: 8]);
    // one SETUP cycle
    check("setup_psel", 32'(bus.PSEL), 32'd1);
    check("setup_penable", 32'(bus.PENABLE), 32'd0);
    check("setup_paddr", bus.PADDR, v.addr);
    check("setup_pwrite", 32'(bus.PWRITE), 32'(v.wr));
    if (v.wr) check("setup_pwdata", bus.PWDATA, v.data);
    bus.PRDATA = v.prdata;
    tick();
    for (int w = 0; w <= v.waits; w++) begin
      bus.PREADY = (w == v.waits);
      if (v.drop && w == 0) begin
        rx_data  = 8'h57;
        rx_valid = 1'b1;
        exp_drop = 1'b1;
      end
      check("access_psel", 32'(bus.PSEL), 32'd1);
      check("access_penable", 32'(bus.PENABLE), 32'd1);
      check("access_paddr", bus.PADDR, v.addr);
      tick();
      rx_valid = 1'b0;
    end
    bus.PREADY = 1'b0;
    bus.PRDATA = ~v.prdata;
    check("resp_psel", 32'(bus.PSEL), 32'd0);
    check("resp_penable", 32'(bus.PENABLE), 32'd0);
    check("resp_busy", 32'(busy), 32'd1);
    nb = v.wr ? 1 : 4;
    idx = 0;
    guard = 0;
    while (idx < nb && guard < 40) begin
      tx_ready = v.toggle ? (guard % 2 == 0) : 1'b1;
      eb = v.wr ? 8'h06 : v.prdata[8*(3-idx) +: 8];
      check("tx_valid", 32'(tx_valid), 32'd1);
      check("tx_data", 32'(tx_data), 32'(eb));
      tick();
      if (tx_ready) idx++;
      guard++;
    end
    tx_ready = 1'b0;
    check("tx_count", idx, nb);
    check("end_busy", 32'(busy), 32'd0);
    check("end_tx_valid", 32'(tx_valid), 32'd0);
    check("drop_err", 32'(drop_err), 32'(exp_drop));
  endtask

  initial begin
    int cnt;
    tbl[0] = '{wr: 1'b1, addr: 32'h4000_0008, data: 32'h0000_00A2, prdata: 32'h0,
               waits: 0, toggle: 1'b0, drop: 1'b0};
    tbl[1] = '{wr: 1'b0, addr: 32'h4000_0004, data: 32'h0, prdata: 32'h1122_3344,
               waits: 3, toggle: 1'b1, drop: 1'b1};
    tbl[2] = '{wr: 1'b0, addr: 32'h0000_0000, data: 32'h0, prdata: 32'hDEAD_BEEF,
               waits: 0, toggle: 1'b0, drop: 1'b0};
    tbl[3] = '{wr: 1'b1, addr: 32'hFFFF_FFFC, data: 32'h1234_5678, prdata: 32'h0,
               waits: 1, toggle: 1'b1, drop: 1'b0};
    tbl[4] = '{wr: 1'b0, addr: 32'hFFFF_FFFF, data: 32'h0, prdata: 32'h0000_0080,
               waits: 2, toggle: 1'b0, drop: 1'b0};

    PRESET     = 1'b1;
    rx_data    = '0;
    rx_valid   = 1'b0;
    tx_ready   = 1'b0;
    bus.PRDATA = '0;
    bus.PREADY = 1'b0;
    tick();
    tick();
    PRESET = 1'b0;

    check("rst_psel", 32'(bus.PSEL), 32'd0);
    check("rst_penable", 32'(bus.PENABLE), 32'd0);
    check("rst_pwrite", 32'(bus.PWRITE), 32'd0);
    check("rst_paddr", bus.PADDR, 32'd0);
    check("rst_pwdata", bus.PWDATA, 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop_err", 32'(drop_err), 32'd0);

    // frames run back-to-back: next command byte lands in the IDLE cycle after the last transfer
    for (int i = 0; i < 5; i++) run_frame(tbl[i]);

    // unknown command byte
    send_byte(8'hAA);
    check("unk_psel", 32'(bus.PSEL), 32'd0);
    check("unk_busy", 32'(busy), 32'd1);
    check("unk_tx_valid", 32'(tx_valid), 32'd1);
    check("unk_tx_data", 32'(tx_data), 32'h15);
    tick();
    check("unk_held", 32'(tx_data), 32'h15);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    check("unk_done_busy", 32'(busy), 32'd0);
    check("unk_done_tx_valid", 32'(tx_valid), 32'd0);
    run_frame(tbl[2]);

    // reset during ACCESS
    send_byte(8'h52);
    for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i));
    tick();
    check("pre_rst_penable", 32'(bus.PENABLE), 32'd1);
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
    exp_drop = 1'b0;
    check("mid_rst_psel", 32'(bus.PSEL), 32'd0);
    check("mid_rst_penable", 32'(bus.PENABLE), 32'd0);
    check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_paddr", bus.PADDR, 32'd0);
    check("mid_rst_drop_err", 32'(drop_err), 32'd0);

    // PREADY held low
    send_byte(8'h57);
    for (int i = 0; i < 8; i++) send_byte(8'(i));
    tick();
`ifdef APB_MASTER_TIMEOUT_EN
    cnt = 0;
    while (bus.PSEL && cnt < 20) begin
      cnt++;
      tick();
    end
    check("timeout_access_cycles", cnt, 4);
    check("timeout_tx_valid", 32'(tx_valid), 32'd1);
    check("timeout_tx_data", 32'(tx_data), 32'h15);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    check("timeout_done_busy", 32'(busy), 32'd0);
`else
    cnt = 0;
    repeat (1000) begin
      tick();
      cnt++;
    end
    check("stall_psel", 32'(bus.PSEL), 32'd1);
    check("stall_penable", 32'(bus.PENABLE), 32'd1);
    check("stall_tx_valid", 32'(tx_valid), 32'd0);
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
    check("stall_rst_busy", 32'(busy), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
